sel_rr_arbiter: RTL
===================

# sel_rr_arbiter

Round-robin arbiter that shares one 8-way active-low select bus between eight requesters. It turns level requests into a registered 3-bit grant index and a one-hot-low select vector `sel_n`, enforces a maximum hold time, and inserts a turnaround gap between owners. It sits in front of the shared resource's chip-select lines and replaces direct static decoding of a select index.

## Interface

**Parameters**
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per owner. 0 means unlimited.
- `TURN_CYC`, default 1: cycles in TURN with all selects inactive after each release. 0 is legal.

**Ports** (clock and reset first)
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst_n`, in, 1: asynchronous assert, active-low reset.
- `en`, in, 1: arbitration enable.
- `req`, in, 8: level requests. Bit i belongs to requester i.
- `gnt_valid`, out, 1: a grant is active.
- `gnt_idx`, out, 3: index of the current owner. Holds its last value when idle.
- `sel_n`, out, 8: active-low one-hot select. All ones when no grant.
- `timeout`, out, 1: one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation

- All outputs are registered.
- Reset values: `gnt_valid`=0, `gnt_idx`=0, `sel_n`=8'hFF, `timeout`=0. Internally: state=IDLE, pointer `ptr`=0, hold counter=0, lockout mask=0.
- **Eligibility:** requester i is eligible when `req[i]`=1 and `lock[i]`=0.
- **Lockout:** `lock[i]` is set when i is revoked by timeout. It clears on any cycle where `req[i]`=0. A timed-out requester must drop `req` for at least one cycle before it can win again.
- **IDLE:**
  - If `en`=1 and any requester is eligible, pick the first eligible index searching upward from `ptr`, wrapping 7→0.
  - At the next edge: `gnt_idx`=winner, `gnt_valid`=1, `sel_n[winner]`=0, counter=1, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:** release when any of the following is sampled:
  - `req[gnt_idx]`=0 (voluntary release);
  - `en`=0 (forced release, no timeout pulse);
  - `MAX_HOLD`≠0 and counter==`MAX_HOLD` (timeout: pulse `timeout`, set `lock[gnt_idx]`). If timeout and a voluntary release coincide, the voluntary release wins: no pulse, no lock.
- **On release:**
  - `gnt_valid`=0, `sel_n`=8'hFF, `ptr`=(`gnt_idx`+1) mod 8.
  - Go to TURN if `TURN_CYC`>0, else to IDLE.
  - Otherwise the counter increments, saturating.
- **TURN:** counts `TURN_CYC` cycles with selects inactive and no arbitration, then goes to IDLE.
- **Invariant:** at most one `sel_n` bit is low in any cycle, and `sel_n`==~(1<<`gnt_idx`) whenever `gnt_valid`=1.
- **Reset mid-grant:** all outputs return to reset values immediately (asynchronous). `ptr` and `lock` are cleared.

## Timing

- Grant latency: a request sampled in IDLE produces `sel_n` low from the next cycle.
- Release latency: `req` low sampled at edge e produces `sel_n` all-ones from edge e.
- Timeout grant: exactly `MAX_HOLD` cycles with `sel_n` low. `timeout` is high in the first inactive cycle.
- Gap between consecutive grants: exactly `TURN_CYC`+1 cycles with `sel_n`=8'hFF (TURN plus one IDLE arbitration cycle).
- `req` changes from non-owners have no effect during GRANT or TURN.

## Structure

- **Package `sel_arb_pkg`:** state enum (IDLE, GRANT, TURN), `N_REQ`=8, `IDX_W`=3, and the `SEL_IDLE`=8'hFF constant.
- **Sub-module `rr_pick`:** purely combinational. Inputs: 8-bit eligible mask and 3-bit `ptr`. Outputs: `found` and a 3-bit index. It implements the rotate-and-priority search.
- **Top level:** FSM, hold and turn counters, lockout mask, and output registers. `sel_n` is decoded from the winner index and registered in the same edge as `gnt_idx`.

## Test plan

- **Reset and single request:** `req`=8'h20 after reset. Expect `gnt_idx`=5 and `sel_n`=8'hDF one cycle later. Drop `req` and expect `sel_n`=8'hFF the same edge. `ptr` becomes 6.
- **Rotation:** `req`=8'hFF held with each owner releasing after 2 cycles. Expect grants in order 0,1,…,7,0 with exactly 2 idle cycles between owners (`TURN_CYC`=1).
- **Timeout and lockout:** `MAX_HOLD`=4, `req`=8'h01 held forever. Expect 4 cycles of `sel_n`=8'hFE, `timeout` pulse, then no further grant. Drop `req[0]` for 1 cycle and reassert; expect a new grant.
- **Simultaneous events:** counter at `MAX_HOLD` in the same cycle as the owner drops `req`. Expect no `timeout` and no lock. Separately, `en`=0 during GRANT gives immediate release without a pulse.
- **Wrap-around:** `ptr`=7 with `req`=8'h81 gives a grant to 7 first, then to 0.
- **Asynchronous reset mid-grant:** assert `rst_n`=0 between edges while `sel_n`=8'hF7. Outputs go to reset values without waiting for a clock edge. After release, `req`=8'h08 gives a grant to 3.

Source files
------------

// File: rtl/sel_arb_pkg.sv
// Shared types and constants for the round-robin select-bus arbiter.
// The state enum, requester count, index width and idle select pattern live here.
package sel_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    localparam logic [N_REQ-1:0] SEL_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

endpackage

// File: rtl/sel_rr_arbiter_rr_pick.sv
// Rotating priority search: the first set bit of elig at or above ptr, wrapping 7 -> 0.
module rr_pick
    import sel_arb_pkg::*;
(
    input  logic [N_REQ-1:0] elig,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sel_rr_arbiter.sv
// Round-robin arbiter driving an 8-way active-low select bus, with a hold limit,
// timeout lockout and a turnaround gap between owners.
//
//  state    | meaning
//  ST_IDLE  | arbitrating; a winner is granted at the next edge
//  ST_GRANT | owner gnt_idx_q holds the bus; hold counter running
//  ST_TURN  | all selects inactive for TURN_CYC cycles, no arbitration
module sel_rr_arbiter
    import sel_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int TURN_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] sel_n,
    output logic             timeout
);

    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int TURN_W = (TURN_CYC < 2) ? 1 : $clog2(TURN_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
    localparam logic [TURN_W-1:0] TURN_LOAD = (TURN_CYC > 0) ? TURN_W'(TURN_CYC - 1) : '0;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TURN_W-1:0]  turn_q, turn_d;
    logic [N_REQ-1:0]   lock_q, lock_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [N_REQ-1:0]   sel_n_q, sel_n_d;
    logic               timeout_q, timeout_d;

    logic [N_REQ-1:0]   elig;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               rel;

    assign elig = en ? (req & ~lock_q) : '0;

    rr_pick u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        turn_d      = turn_q;
        lock_d      = lock_q & req;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        sel_n_d     = sel_n_q;
        timeout_d   = 1'b0;
        rel         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d            = ST_GRANT;
                    gnt_valid_d        = 1'b1;
                    gnt_idx_d          = pick_idx;
                    sel_n_d            = SEL_IDLE;
                    sel_n_d[pick_idx]  = 1'b0;
                    hold_d             = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                // Voluntary release outranks a coincident timeout: no pulse, no lock.
                if (!req[gnt_idx_q]) begin
                    rel = 1'b1;
                end else if (!en) begin
                    rel = 1'b1;
                end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LIM)) begin
                    rel               = 1'b1;
                    timeout_d         = 1'b1;
                    lock_d[gnt_idx_q] = 1'b1;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end

                if (rel) begin
                    gnt_valid_d = 1'b0;
                    sel_n_d     = SEL_IDLE;
                    ptr_d       = gnt_idx_q + 1'b1;
                    turn_d      = TURN_LOAD;
                    state_d     = (TURN_CYC > 0) ? ST_TURN : ST_IDLE;
                end
            end
            ST_TURN: begin
                if (turn_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            turn_q      <= '0;
            lock_q      <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            sel_n_q     <= SEL_IDLE;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            turn_q      <= turn_d;
            lock_q      <= lock_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            sel_n_q     <= sel_n_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign sel_n     = sel_n_q;
    assign timeout   = timeout_q;

endmodule
